// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and saturating-increment helper for the timer group
// Contents: state_t (IDLE, ARMED, RUN, HOLD as 2-bit codes) and sat_full(), which reports
// whether a w-bit counter is at its maximum, so an increment must saturate instead.
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  function automatic logic sat_full(input logic [31:0] v, input int unsigned w);
    return v == (32'hffff_ffff >> (32 - w));
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescale phase counter that raises tick on the last phase of every P cycles
// Ports: clock, reset (sync, active-high), clear (sync restart at phase 0),
// enable (advance one phase), tick (phase == P-1).
module tick_divider #(
  parameter int P = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(P);
  logic [CW-1:0] pc;
  assign tick = pc == CW'(P - 1);
  always_ff @(posedge clock)
    if (reset || clear) pc <= '0;
    else if (enable) pc <= tick ? '0 : pc + 1'b1;
endmodule

// File: rtl/interval_meter.sv
// interval_meter: counts cycles (or prescaled ticks) between two mark strobes, result via valid/ready
// Ports: clock, reset (sync, active-high), arm (start request), mark (event strobe),
// result[W] / overflow (measured interval, saturation flag), valid / ready (handshake), busy.
// Option: INTERVAL_METER_PRESCALE_EN adds parameter P and divides the count by P.
module interval_meter
  import timer_pkg::*;
#(
  parameter int W = 8
`ifdef INTERVAL_METER_PRESCALE_EN
  , parameter int P = 4
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         arm,
  input  logic         mark,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         valid,
  input  logic         ready,
  output logic         busy
);
  state_t state;
  logic [W-1:0] count;
  logic tick, full;
  assign full = sat_full(32'(count), W);
`ifdef INTERVAL_METER_PRESCALE_EN
  tick_divider #(.P(P)) u_div (
    .clock(clock),
    .reset(reset),
    .clear(state == ARMED && mark),
    .enable(state == RUN && !mark),
    .tick(tick)
  );
`else
  assign tick = 1'b1;
`endif
  // On the stopping mark the final phase still counts, so a pending tick adds one more.
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      result <= '0;
      overflow <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      count <= '0;
    end else
      case (state)
        IDLE:
          if (arm) begin
            state <= ARMED;
            overflow <= 1'b0;
            busy <= 1'b1;
          end
        ARMED:
          if (mark) begin
            state <= RUN;
            count <= '0;
          end
        RUN:
          if (mark) begin
            state <= HOLD;
            valid <= 1'b1;
            busy <= 1'b0;
            result <= (tick && !full) ? count + 1'b1 : count;
            overflow <= overflow | (tick && full);
          end else if (tick) begin
            count <= full ? count : count + 1'b1;
            overflow <= overflow | full;
          end
        HOLD:
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed and random checks of interval_meter against an arithmetic model
module tb_interval_meter;
  localparam int W = 4;
  localparam int MAX = 15;
`ifdef INTERVAL_METER_PRESCALE_EN
  localparam int P = 4;
  localparam int DS[5] = '{9, 8, 3, 1, 70};
  localparam int ER[5] = '{2, 2, 0, 0, 15};
  localparam int EO[5] = '{0, 0, 0, 0, 1};
`else
  localparam int P = 1;
  localparam int DS[5] = '{5, 20, 3, 1, 2};
  localparam int ER[5] = '{5, 15, 3, 1, 2};
  localparam int EO[5] = '{0, 1, 0, 0, 0};
`endif
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_HOLD = 3;

  logic clock = 0, reset = 1, arm = 0, mark = 0, ready = 0;
  logic [W-1:0] result;
  logic overflow, valid, busy;
  int checks = 0, errors = 0;
  bit go = 0;

  interval_meter #(
    .W(W)
`ifdef INTERVAL_METER_PRESCALE_EN
    , .P(P)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .arm(arm),
    .mark(mark),
    .result(result),
    .overflow(overflow),
    .valid(valid),
    .ready(ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Model: el counts RUN cycles since the starting mark; the interval is el+1 cycles,
  // the answer is floor(d/P) clipped to MAX, and overflow means the unclipped quotient exceeded MAX.
  int ph = M_IDLE, el = 0, q = 0;
  int e_res = 0, e_ovf = 0, e_valid = 0, e_busy = 0;
  always @(posedge clock) begin
    if (reset) begin
      ph = M_IDLE; el = 0; e_res = 0; e_ovf = 0;
    end else if (ph == M_IDLE) begin
      if (arm) begin ph = M_ARMED; e_ovf = 0; end
    end else if (ph == M_ARMED) begin
      if (mark) begin ph = M_RUN; el = 0; end
    end else if (ph == M_RUN) begin
      if (mark) begin
        q = (el + 1) / P;
        e_res = q > MAX ? MAX : q;
        e_ovf = q > MAX ? 1 : 0;
        ph = M_HOLD;
      end else begin
        el++;
        e_ovf = (el / P) > MAX ? 1 : 0;
      end
    end else if (ready) ph = M_IDLE;
    e_valid = ph == M_HOLD ? 1 : 0;
    e_busy = (ph == M_ARMED || ph == M_RUN) ? 1 : 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (go) begin
      chk("result", 32'(result), e_res);
      chk("overflow", 32'(overflow), e_ovf);
      chk("valid", 32'(valid), e_valid);
      chk("busy", 32'(busy), e_busy);
    end

  task automatic measure(input int d, input int er, input int eo, input int stall);
    ready = (stall == 0);
    @(negedge clock) arm = 1;
    @(negedge clock) arm = 0; mark = 1;
    @(negedge clock) mark = 0;
    chk("busy_run", 32'(busy), 1);
    repeat (d - 1) @(negedge clock);
    mark = 1;
    @(negedge clock) mark = 0;
    chk("valid_rise", 32'(valid), 1);
    chk("result_lit", 32'(result), er);
    chk("overflow_lit", 32'(overflow), eo);
    chk("model_result_lit", e_res, er);
    chk("model_overflow_lit", e_ovf, eo);
    for (int i = 0; i < stall; i++) begin
      arm = i[0];
      mark = !i[0];
      @(negedge clock);
      chk("hold_result", 32'(result), er);
      chk("hold_valid", 32'(valid), 1);
    end
    arm = 0; mark = 0; ready = 1;
    @(negedge clock);
    chk("valid_drop", 32'(valid), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    go = 1;
    chk("reset_result", 32'(result), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 0;
    mark = 1;
    @(negedge clock) mark = 0;
    chk("mark_in_idle", 32'(busy), 0);
    for (int k = 0; k < 5; k++) measure(DS[k], ER[k], EO[k], 0);
    measure(DS[0], ER[0], EO[0], 4);
    @(negedge clock) arm = 1;
    @(negedge clock) arm = 0; mark = 1;
    @(negedge clock) mark = 0;
    repeat (3) @(negedge clock);
    chk("busy_before_reset", 32'(busy), 1);
    reset = 1;
    @(negedge clock) reset = 0;
    chk("rst_run_result", 32'(result), 0);
    chk("rst_run_overflow", 32'(overflow), 0);
    chk("rst_run_valid", 32'(valid), 0);
    chk("rst_run_busy", 32'(busy), 0);
    mark = 1;
    @(negedge clock) mark = 0;
    repeat (3) begin
      @(negedge clock);
      chk("no_arm_busy", 32'(busy), 0);
      chk("no_arm_valid", 32'(valid), 0);
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      reset = $urandom_range(0, 199) == 0;
      arm = $urandom_range(0, 3) == 0;
      mark = $urandom_range(0, 7) == 0;
      ready = $urandom_range(0, 2) != 0;
    end
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/interval_meter.md
# interval_meter

Measures the number of clock cycles (or prescaled ticks) between two strobes on `mark` and delivers the result over a valid/ready handshake. It is the measuring counterpart of the countdown timer: the countdown timer is loaded with a duration and runs it down, while this block counts up from an observed event and reports the elapsed duration. It sits in the timer group next to the countdown timer and feeds software-visible capture registers or a calibration FSM.

## Interface
- `W`, default 8: counter and result width.
- `P`, default 4: prescale divisor, P ≥ 2. Exists only when `INTERVAL_METER_PRESCALE_EN` is defined.

Ports:
- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset: synchronous, active-high.
- `arm`  in  1  one-cycle request to start a measurement. Honoured only in IDLE.
- `mark`  in  1  event strobe. The first mark after arm starts counting; the second mark stops it.
- `result`  out  W  measured interval, registered.
- `overflow`  out  1  the count saturated during this measurement.
- `valid`  out  1  `result` and `overflow` are valid.
- `ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in ARMED or RUN.

## Operation
- States:
  - IDLE.
  - ARMED: waiting for the first mark.
  - RUN: counting.
  - HOLD: result presented.
- IDLE → ARMED on `arm`. Entering ARMED also clears `overflow`. `mark` in IDLE is ignored, including when it coincides with `arm`.
- ARMED → RUN on `mark`. This loads the internal count to 0 and the prescale phase `pc` to 0.
- Each RUN cycle without `mark`:
  - If `pc == P-1`: set `pc` to 0 and increment the count.
  - Otherwise: increment `pc`.
  - The count saturates at 2^W−1. An increment attempted at the maximum sets `overflow`.
- RUN → HOLD on `mark`:
  - `result` is loaded with the count plus 1 when `pc == P-1`, otherwise with the count. The same saturation and overflow rule applies.
  - The result therefore equals floor(d/P), where d is the number of cycles between the two marks.
- HOLD: `valid` = 1. `result` and `overflow` stay stable. `arm` and `mark` are ignored.
- HOLD → IDLE on the cycle where `valid && ready`.
- `arm` in ARMED, RUN or HOLD is ignored.
- `busy` = (state == ARMED || state == RUN), registered with the state.

## Timing
- Reset values: state IDLE, `result` = 0, `overflow` = 0, `valid` = 0, `busy` = 0, internal count = 0, `pc` = 0.
- `reset` overrides all inputs in the same cycle. Reset in any state, mid-measurement included, returns to IDLE with the reset values above.
- Latency: `valid` rises on the clock edge that samples the second `mark`, i.e. it is visible in the following cycle.
- `ready` may be held high in advance. The minimum HOLD occupancy is one cycle.
- Earliest re-arm: the cycle after the handshake, since the block is then in IDLE.
- Marks on consecutive cycles give d = 1, so the result is 1 without prescale and 0 with prescale.
- A `mark` pulse held high for several cycles counts as successive marks: one in ARMED, then one in RUN.

## Configuration
- `INTERVAL_METER_PRESCALE_EN` defined:
  - Parameter `P` and the `pc` phase counter (width $clog2(P)) exist.
  - The count advances once every P cycles and the result is floor(d/P).
- Not defined:
  - No prescaler logic. This behaves as P = 1: the count advances every RUN cycle and the result is d.

## Structure
- Shared package `timer_pkg` holds the state encoding of IDLE, ARMED, RUN and HOLD as 2-bit localparams/typedef, plus the saturating-increment helper function.
- One sub-module, `tick_divider`: the prescale phase counter with a synchronous clear and a `tick` output. It is instantiated only under `INTERVAL_METER_PRESCALE_EN`.

## Test plan
- Reset, arm, mark at t0, mark at t0+5, `ready` = 1 → `valid` for one cycle with `result` = 5, `overflow` = 0, then `busy` = 0.
- W = 4, marks 20 cycles apart → `result` = 15, `overflow` = 1. A following measurement with d = 3 → `result` = 3, `overflow` = 0.
- Marks on two consecutive cycles (no prescale) → `result` = 1.
- Result presented with `ready` = 0 for 4 cycles while `mark` and `arm` toggle → `result` and `valid` stay stable. Raising `ready` → `valid` drops the next cycle and the state is IDLE.
- Reset asserted in RUN → all outputs 0. A subsequent `mark` without `arm` → no `busy`, no `valid`.
- With `INTERVAL_METER_PRESCALE_EN` and P = 4: d = 9 → `result` = 2; d = 8 → `result` = 2; d = 3 → `result` = 0.
